fifo_stream_reader: RTL and testbench

//  Reader-side endpoint of the FWFT FIFO interface: pops words from an upstream

---
 rtl/fifo_stream_pkg.sv | 13 +
 rtl/fifo_stream_skid2.sv | 74 +++++++
 rtl/fifo_stream_reader.sv | 61 ++++++
 tb/tb_fifo_stream_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FWFT FIFO stream reader.
// Occupancy encodings of the 2-entry skid buffer.
package fifo_stream_pkg;

   localparam int CNT_W = 2;

   typedef enum logic [CNT_W-1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_TWO   = 2'd2
   } cnt_e;

endpackage

// File: rtl/fifo_stream_skid2.sv
// Two-slot skid storage with occupancy state for the stream reader.
// head_q is the presented word, tail_q catches one word during a stall.
module fifo_stream_skid2
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [CNT_W-1:0]      cnt,
   output logic [DATA_WIDTH-1:0] head
);

   cnt_e                  cnt_q;
   cnt_e                  cnt_d;
   logic                  ld_head_in;
   logic                  ld_head_tail;
   logic                  ld_tail;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;

   // Occupancy register; reset drops any buffered words.
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= CNT_EMPTY;
      else        cnt_q <= cnt_d;
   end

   // Next occupancy and slot load selects.
   always_comb begin
      cnt_d        = cnt_q;
      ld_head_in   = 1'b0;
      ld_head_tail = 1'b0;
      ld_tail      = 1'b0;
      unique case (cnt_q)
         CNT_EMPTY: begin
            if (push) begin
               cnt_d      = CNT_ONE;
               ld_head_in = 1'b1;
            end
         end
         CNT_ONE: begin
            if (push && !pop) begin
               cnt_d   = CNT_TWO;
               ld_tail = 1'b1;
            end else if (push && pop) begin
               ld_head_in = 1'b1;
            end else if (pop) begin
               cnt_d = CNT_EMPTY;
            end
         end
         CNT_TWO: begin
            if (pop) begin
               cnt_d        = CNT_ONE;
               ld_head_tail = 1'b1;
            end
         end
         default: cnt_d = CNT_EMPTY;
      endcase
   end

   // Data slots are not reset; contents only matter when occupied.
   always_ff @(posedge clk) begin
      if (ld_head_in)        head_q <= din;
      else if (ld_head_tail) head_q <= tail_q;
      if (ld_tail)           tail_q <= din;
   end

   assign cnt  = cnt_q;
   assign head = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// FWFT FIFO reader endpoint re-issuing words as a valid/ready stream.
// Optional stall counter enabled by FIFO_STREAM_READER_STALL_CNT_EN.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       if_empty_n,
   input  logic [DATA_WIDTH-1:0]      if_dout,
   output logic                       if_read,
   output logic                       if_read_ce,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

   logic [CNT_W-1:0] cnt;
   logic             pop;

   // if_read depends only on registered occupancy, never on m_ready.
   assign if_read    = reset && if_empty_n && (cnt != CNT_TWO);
   assign if_read_ce = 1'b1;
   assign m_valid    = (cnt != CNT_EMPTY);
   assign pop        = m_valid && m_ready;

   fifo_stream_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .push  (if_read),
      .pop   (pop),
      .din   (if_dout),
      .cnt   (cnt),
      .head  (m_data)
   );

`ifdef FIFO_STREAM_READER_STALL_CNT_EN
   localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;

   logic [STALL_CNT_WIDTH-1:0] stall_q;

   // Saturating count of cycles the consumer holds off valid data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (m_valid && !m_ready && (stall_q != '1)) begin
         stall_q <= stall_q + STALL_ONE;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader.
// Vector table, hand sequences and a queue-based random reference.
module tb_fifo_stream_reader;

   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_empty_n;
   logic [DW-1:0] if_dout;
   logic          if_read;
   logic          if_read_ce;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [SW-1:0] stall_cnt;

   fifo_stream_reader #(
      .DATA_WIDTH      (DW),
      .STALL_CNT_WIDTH (SW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_empty_n (if_empty_n),
      .if_dout    (if_dout),
      .if_read    (if_read),
      .if_read_ce (if_read_ce),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          r;
      logic          e;
      logic          rdy;
      logic          x_rd;
      logic          x_v;
      logic          chk_d;
      logic [DW-1:0] x_d;
   } vec_t;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] src_idx = 0;
   int            exp_stall = 0;
   bit            model_ok = 0;
   logic          cur_r, cur_e, cur_rdy;
   vec_t          tbl[18];

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
      end
   endtask

   // Apply inputs on the falling edge and check against the model.
   task automatic drive(input logic r, input logic e, input logic rdy);
      @(negedge clk);
      reset      = r;
      if_empty_n = e;
      m_ready    = rdy;
      if_dout    = src_idx;
      cur_r      = r;
      cur_e      = e;
      cur_rdy    = rdy;
      #1;
      chk("if_read_ce", {31'd0, if_read_ce}, 1);
      if (model_ok) begin
         chk("mdl_if_read", {31'd0, if_read},
             {31'd0, r && e && (q.size() < 2)});
         chk("mdl_m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0) chk("mdl_m_data", m_data, q[0]);
         chk("mdl_stall_cnt", {28'd0, stall_cnt}, exp_stall);
      end
   endtask

   // Advance the reference model across the rising edge.
   task automatic advance();
      bit push;
      @(posedge clk);
      push = cur_r && cur_e && (q.size() < 2);
      if (!cur_r) begin
         q.delete();
         exp_stall = 0;
         model_ok  = 1;
      end else begin
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
         if (q.size() != 0 && !cur_rdy && exp_stall < 15) exp_stall++;
`endif
         if (q.size() != 0 && cur_rdy) void'(q.pop_front());
         if (push) begin
            q.push_back(src_idx);
            src_idx++;
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic rdy);
      drive(r, e, rdy);
      advance();
   endtask

   initial begin
      logic [DW-1:0] nxt;

      // r e rdy | if_read m_valid chk_d data
      tbl[0]  = '{0, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 1, 1, 1, 0, 0, 0};
      tbl[4]  = '{1, 1, 1, 1, 1, 1, 0};
      tbl[5]  = '{1, 1, 1, 1, 1, 1, 1};
      tbl[6]  = '{1, 1, 1, 1, 1, 1, 2};
      tbl[7]  = '{1, 1, 1, 1, 1, 1, 3};
      tbl[8]  = '{1, 1, 1, 1, 1, 1, 4};
      tbl[9]  = '{1, 1, 0, 1, 1, 1, 5};
      tbl[10] = '{1, 1, 0, 0, 1, 1, 5};
      tbl[11] = '{1, 1, 0, 0, 1, 1, 5};
      tbl[12] = '{1, 1, 1, 0, 1, 1, 5};
      tbl[13] = '{1, 1, 1, 1, 1, 1, 6};
      tbl[14] = '{1, 1, 1, 1, 1, 1, 7};
      tbl[15] = '{1, 1, 1, 1, 1, 1, 8};
      tbl[16] = '{1, 0, 1, 0, 1, 1, 9};
      tbl[17] = '{1, 0, 1, 0, 0, 0, 0};

      reset      = 1'b0;
      if_empty_n = 1'b0;
      m_ready    = 1'b0;
      if_dout    = '0;
      step(0, 1, 1);

      // Reset hold, release, streaming start, backpressure, drain.
      src_idx = 0;
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].e, tbl[i].rdy);
         chk($sformatf("tbl%0d_if_read", i), {31'd0, if_read},
             {31'd0, tbl[i].x_rd});
         chk($sformatf("tbl%0d_m_valid", i), {31'd0, m_valid},
             {31'd0, tbl[i].x_v});
         if (tbl[i].chk_d)
            chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].x_d);
         advance();
      end

      // 100-word stream: one word per cycle, 1-cycle latency.
      step(0, 1, 1);
      src_idx = 0;
      for (int i = 0; i <= 100; i++) begin
         drive(1, 1, 1);
         if (i >= 1) begin
            chk("stream_valid", {31'd0, m_valid}, 1);
            chk("stream_data", m_data, i - 1);
         end
         advance();
      end

      // Mid-flight reset with two buffered words.
      step(0, 1, 1);
      src_idx = 32'h100;
      step(1, 1, 0);
      step(1, 1, 0);
      drive(1, 1, 0);
      chk("mid_full_if_read", {31'd0, if_read}, 0);
      chk("mid_full_head", m_data, 32'h100);
      advance();
      step(0, 1, 1);
      nxt = src_idx;
      drive(1, 1, 1);
      chk("mid_rel_valid", {31'd0, m_valid}, 0);
      chk("mid_rel_if_read", {31'd0, if_read}, 1);
      advance();
      drive(1, 1, 1);
      chk("mid_first_valid", {31'd0, m_valid}, 1);
      chk("mid_first_data", m_data, nxt);
      advance();

      // Stall counter saturation.
      step(0, 1, 0);
      for (int i = 0; i < 22; i++) step(1, 1, 0);
      drive(1, 1, 0);
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
      chk("stall_sat", {28'd0, stall_cnt}, 15);
`else
      chk("stall_off", {28'd0, stall_cnt}, 0);
`endif
      advance();

      // Random traffic against the queue model.
      step(0, 0, 0);
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 199) != 0),
              $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
